issue_ctrl: RTL and testbench
=============================

# issue_ctrl

In-order issue controller for the Tomasulo core. It buffers fetched 16-bit instructions in a small queue and decodes the head entry. It dispatches that entry to the add/sub or load/store reservation stations when a free station exists. It also maintains the register status table (rename tags) that supplies source operand tags to the stations and is cleared by the common data bus (CDB).

## Interface
- DEPTH, 4: instruction queue entries (power of two, ≥2)
- TAGW, 3: station tag width; tag 0 means "value ready / no producer"
- CLK  in  1  clock, all state updates on rising edge
- CLR  in  1  reset, asynchronous, active-high
- instr_valid  in  1  fetch offers instr this cycle
- instr  in  16  opcode[2:0], rd[5:3], rs[8:6], offset[15:9]
- instr_ready  out  1  queue can accept (count < DEPTH)
- ASFull / LSFull  in  1  add/sub / load-store stations have no free entry
- as_tag / ls_tag  in  TAGW  tag of next free AS / LS entry (nonzero when not full)
- cdb_valid  in  1  CDB broadcast this cycle
- cdb_tag  in  TAGW  producing station tag
- as_issue / ls_issue  out  1  one-cycle issue strobe to AS / LS stations
- iss_op  out  3  issued opcode
- iss_rd, iss_rs  out  3  issued register fields
- iss_offset  out  7  issued offset
- iss_qj  out  TAGW  producer tag for the rd-as-source operand (0 = ready)
- iss_qk  out  TAGW  producer tag for rs (0 = ready)
- stall_cnt  out  8  saturating count of structural-stall cycles

## Operation
- Opcodes: 000 ADD and 001 SUB (rd ← rd op rs, AS class); 010 LD (rd ← mem[rs+offset], LS class); 011 ST (mem[rs+offset] ← rd, LS class). 100–111 are reserved.
- Queue push: on an edge where instr_valid && instr_ready, write instr at the tail and advance the tail. Push while full is ignored.
- Head issuable: queue not empty and the target class is not full, sampled at the edge.
- On issue:
  - Pop the head.
  - Register iss_* fields.
  - Pulse as_issue or ls_issue high for exactly one cycle.
- Source tags:
  - iss_qj = status[rd].
  - iss_qk = status[rs].
  - ST uses both qj and qk; LD ignores qj, which is still output.
- Rename:
  - ADD, SUB and LD write status[rd] ← allocated tag (as_tag or ls_tag).
  - ST writes nothing.
- CDB: when cdb_valid is high, every status entry equal to cdb_tag is cleared to 0.
- Same-edge interactions:
  - CDB bypass: if a source's status equals cdb_tag while cdb_valid is high at the issue edge, the corresponding iss_q* output is 0.
  - Issue rename and CDB clear hit the same register: the issue write wins (new tag stored).
  - Status reads use pre-update values, so for ADD r1,r1 the qj/qk come from the old status[r1].
- Reserved opcode at head: popped with no issue strobe and no status change; this consumes one cycle.
- Head blocked by its full class: the head stays; instructions behind it never bypass it (strict in-order). stall_cnt increments once per blocked cycle, saturating at 255.
- Simultaneous push and pop: the count is unchanged; pointers wrap modulo DEPTH.

## Timing
- CLR asserted, immediate (asynchronous):
  - Queue empty; all status entries 0.
  - as_issue, ls_issue, iss_op, iss_rd, iss_rs, iss_offset, iss_qj, iss_qk and stall_cnt are all 0.
  - instr_ready = 1.
- CLR asserted mid-operation: queued instructions are discarded, and any in-progress strobe drops immediately.
- Latency: an instruction pushed at edge N issues at edge N+1 at the earliest, so its strobe is high during cycle N+1→N+2. Sustained throughput is one issue per cycle.
- instr_ready is combinational from the registered count.
- ASFull and LSFull are sampled at the issue edge. The station must present a valid tag in the same cycle that full is low.
- Strobes are never high two cycles for the same instruction. iss_* fields hold their last value when no strobe is high.

## Test plan
- Reset:
  - Stimulus: CLR pulse mid-stream with 3 entries queued.
  - Required response: all outputs 0, instr_ready = 1. After release, no issue occurs until a new push.
- Basic rename/dependency:
  - Setup: as_tag = 1, ls_tag = 5.
  - Stimulus: push ADD r1,r2 then LD r3,r1,+4.
  - Required response: the ADD issues with qj = 0, qk = 0. The LD issues next cycle with qk = 1 and status[r3] = 5.
- CDB clear and bypass:
  - Setup: status[r1] = 1.
  - Stimulus: cdb_valid with cdb_tag = 1 on the same edge that SUB r4,r1 issues.
  - Required response: iss_qk = 0 and status[r1] = 0.
  - Second check: rename of r1 to tag 2 on the same edge as a CDB clear of tag 1 leaves status[r1] = 2.
- Structural stall:
  - Stimulus: hold LSFull = 1 with ST at the head and ADD behind it, for 3 cycles.
  - Required response: no strobe; the ADD does not bypass; stall_cnt = 3.
  - After release: ST issues, then ADD.
- Queue full and wrap:
  - Stimulus: push 4 instructions with both classes full, then offer a 5th.
  - Required response: instr_ready = 0 and the 5th is not accepted.
  - After release: 4 issues in order; then 6 more pushes issue correctly across the pointer wrap.
- Reserved opcode: a queued 3'b110 is popped without a strobe, and the following ADD issues on the next cycle.

Source files
------------

// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order instruction queue with rename table that dispatches to AS/LS reservation stations
module issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAGW = 3
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            instr_valid,
  input  logic [15:0]     instr,
  output logic            instr_ready,
  input  logic            ASFull,
  input  logic            LSFull,
  input  logic [TAGW-1:0] as_tag,
  input  logic [TAGW-1:0] ls_tag,
  input  logic            cdb_valid,
  input  logic [TAGW-1:0] cdb_tag,
  output logic            as_issue,
  output logic            ls_issue,
  output logic [2:0]      iss_op,
  output logic [2:0]      iss_rd,
  output logic [2:0]      iss_rs,
  output logic [6:0]      iss_offset,
  output logic [TAGW-1:0] iss_qj,
  output logic [TAGW-1:0] iss_qk,
  output logic [7:0]      stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic [TAGW-1:0] status [8];
  logic [15:0] h;
  logic [2:0] op, rd, rs;
  logic nonempty, is_as, is_ls, rsv, do_issue, blocked, pop, push;
  logic [TAGW-1:0] tag, qj, qk;
  assign instr_ready = count != FULL;
  assign h = mem[head];
  assign op = h[2:0];
  assign rd = h[5:3];
  assign rs = h[8:6];
  // head decode: class, issue/stall decision, allocated tag and bypassed source tags
  always_comb begin
    nonempty = count != '0;
    is_as = nonempty && op[2:1] == 2'b00;
    is_ls = nonempty && op[2:1] == 2'b01;
    rsv = nonempty && op[2];
    do_issue = (is_as && !ASFull) || (is_ls && !LSFull);
    blocked = (is_as && ASFull) || (is_ls && LSFull);
    pop = do_issue || rsv;
    push = instr_valid && instr_ready;
    tag = is_as ? as_tag : ls_tag;
    qj = (cdb_valid && status[rd] == cdb_tag) ? '0 : status[rd];
    qk = (cdb_valid && status[rs] == cdb_tag) ? '0 : status[rs];
  end
  // queue storage needs no reset; only the pointers define what is valid
  always_ff @(posedge CLK) begin
    if (push) mem[tail] <= instr;
  end
  // queue pointers and occupancy
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop) head <= head + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // register status table: an issuing rename overrides a same-edge CDB clear
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < 8; i++) status[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (do_issue && op != 3'd3 && rd == 3'(i)) status[i] <= tag;
        else if (cdb_valid && status[i] == cdb_tag) status[i] <= '0;
    end
  end
  // issue strobes, held issue fields and saturating stall counter
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      as_issue <= 1'b0;
      ls_issue <= 1'b0;
      iss_op <= '0;
      iss_rd <= '0;
      iss_rs <= '0;
      iss_offset <= '0;
      iss_qj <= '0;
      iss_qk <= '0;
      stall_cnt <= '0;
    end else begin
      as_issue <= do_issue && is_as;
      ls_issue <= do_issue && is_ls;
      if (do_issue) begin
        iss_op <= op;
        iss_rd <= rd;
        iss_rs <= rs;
        iss_offset <= h[15:9];
        iss_qj <= qj;
        iss_qk <= qk;
      end
      if (blocked && stall_cnt != 8'hff) stall_cnt <= stall_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed and randomized checks of issue_ctrl against a queue/array reference model
module tb_issue_ctrl;
  localparam int DEPTH = 4;
  localparam int TAGW = 3;
  logic CLK = 0, CLR = 0;
  logic instr_valid = 0;
  logic [15:0] instr = '0;
  logic instr_ready;
  logic ASFull = 0, LSFull = 0;
  logic [TAGW-1:0] as_tag = 3'd1, ls_tag = 3'd5;
  logic cdb_valid = 0;
  logic [TAGW-1:0] cdb_tag = '0;
  logic as_issue, ls_issue;
  logic [2:0] iss_op, iss_rd, iss_rs;
  logic [6:0] iss_offset;
  logic [TAGW-1:0] iss_qj, iss_qk;
  logic [7:0] stall_cnt;
  int checks = 0, errors = 0;

  issue_ctrl #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .CLK(CLK), .CLR(CLR), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .ASFull(ASFull), .LSFull(LSFull), .as_tag(as_tag), .ls_tag(ls_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .as_issue(as_issue), .ls_issue(ls_issue),
    .iss_op(iss_op), .iss_rd(iss_rd), .iss_rs(iss_rs), .iss_offset(iss_offset),
    .iss_qj(iss_qj), .iss_qk(iss_qk), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  logic [32:0] obs;
  logic [16:0] iv;
  assign obs = {as_issue, ls_issue, iss_op, iss_rd, iss_rs, iss_offset, iss_qj, iss_qk, stall_cnt, instr_ready};
  assign iv = {as_issue, ls_issue, iss_op, iss_rd, iss_rs, iss_qj, iss_qk};

  logic [15:0] q[$];
  logic [TAGW-1:0] st [8];
  logic e_as, e_ls;
  logic [2:0] e_op, e_rd, e_rs;
  logic [6:0] e_off;
  logic [TAGW-1:0] e_qj, e_qk;
  logic [7:0] e_stall;

  function automatic logic [15:0] mk(int op, int rd, int rs, int off);
    return {7'(off), 3'(rs), 3'(rd), 3'(op)};
  endfunction

  function automatic logic [32:0] exp_vec();
    return {e_as, e_ls, e_op, e_rd, e_rs, e_off, e_qj, e_qk, e_stall, q.size() < DEPTH};
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 8; i++) st[i] = '0;
    {e_as, e_ls, e_op, e_rd, e_rs, e_off, e_qj, e_qk, e_stall} = '0;
  endtask

  task automatic tick();
    logic [15:0] hd, pin;
    logic take, full;
    logic [TAGW-1:0] nt;
    @(posedge CLK);
    take = instr_valid && q.size() < DEPTH;
    pin = instr;
    e_as = 0;
    e_ls = 0;
    nt = '0;
    if (q.size() > 0) begin
      hd = q[0];
      if (hd[2:0] >= 3'd4) void'(q.pop_front());
      else begin
        full = (hd[2:0] < 3'd2) ? ASFull : LSFull;
        if (full) begin
          if (e_stall != 8'd255) e_stall = e_stall + 8'd1;
        end else begin
          e_as = hd[2:0] < 3'd2;
          e_ls = !e_as;
          e_op = hd[2:0];
          e_rd = hd[5:3];
          e_rs = hd[8:6];
          e_off = hd[15:9];
          e_qj = (cdb_valid && st[e_rd] == cdb_tag) ? '0 : st[e_rd];
          e_qk = (cdb_valid && st[e_rs] == cdb_tag) ? '0 : st[e_rs];
          nt = e_as ? as_tag : ls_tag;
          void'(q.pop_front());
        end
      end
    end
    if (cdb_valid) for (int i = 0; i < 8; i++) if (st[i] == cdb_tag) st[i] = '0;
    if ((e_as || e_ls) && e_op != 3'd3) st[e_rd] = nt;
    if (take) q.push_back(pin);
    #1;
  endtask

  task automatic push(logic [15:0] w);
    instr_valid = 1;
    instr = w;
    tick();
    instr_valid = 0;
  endtask

  task automatic idle();
    instr_valid = 0;
    tick();
  endtask

  task automatic test_reset();
    #2 CLR = 1;
    #1 model_reset();
    checks++; if (obs !== 33'h1) begin errors++; $display("FAIL reset_init got %h want %h", obs, 33'h1); end
    @(negedge CLK) CLR = 0;
    ASFull = 1;
    as_tag = 3'd1;
    push(mk(0, 1, 2, 0));
    push(mk(0, 2, 3, 0));
    push(mk(0, 3, 4, 0));
    ASFull = 0;
    push(mk(0, 4, 5, 0));
    checks++; if (obs !== exp_vec() || as_issue !== 1'b1) begin errors++; $display("FAIL reset_prestate got %h want %h", obs, exp_vec()); end
    #2 CLR = 1;
    #1 model_reset();
    checks++; if (obs !== 33'h1) begin errors++; $display("FAIL reset_async got %h want %h", obs, 33'h1); end
    @(negedge CLK) CLR = 0;
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if ({as_issue, ls_issue} !== 2'b00) begin errors++; $display("FAIL reset_noissue cyc %0d got %b want 00", i, {as_issue, ls_issue}); end
    end
    checks++; if (obs !== 33'h1) begin errors++; $display("FAIL reset_after got %h want %h", obs, 33'h1); end
  endtask

  task automatic test_rename();
    as_tag = 3'd1;
    ls_tag = 3'd5;
    push(mk(0, 1, 2, 0));
    push(mk(2, 3, 1, 4));
    checks++; if (iv !== {1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0}) begin errors++; $display("FAIL rename_add got %h", iv); end
    idle();
    checks++; if (iv !== {1'b0, 1'b1, 3'd2, 3'd3, 3'd1, 3'd0, 3'd1} || iss_offset !== 7'd4) begin errors++; $display("FAIL rename_ld got %h off %0d want qk 1 off 4", iv, iss_offset); end
    push(mk(3, 3, 0, 0));
    idle();
    checks++; if (iv !== {1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 3'd5, 3'd0}) begin errors++; $display("FAIL rename_st got %h want qj 5", iv); end
  endtask

  task automatic test_cdb();
    push(mk(1, 4, 1, 0));
    cdb_valid = 1; cdb_tag = 3'd1; as_tag = 3'd2;
    idle();
    cdb_valid = 0;
    checks++; if (iv !== {1'b1, 1'b0, 3'd1, 3'd4, 3'd1, 3'd0, 3'd0}) begin errors++; $display("FAIL cdb_bypass got %h want qk 0", iv); end
    push(mk(0, 5, 1, 0));
    as_tag = 3'd3;
    idle();
    checks++; if (iv !== {1'b1, 1'b0, 3'd0, 3'd5, 3'd1, 3'd0, 3'd0}) begin errors++; $display("FAIL cdb_cleared got %h want qk 0", iv); end
    as_tag = 3'd1;
    push(mk(0, 1, 0, 0));
    idle();
    push(mk(0, 1, 0, 0));
    as_tag = 3'd2; cdb_valid = 1; cdb_tag = 3'd1;
    idle();
    cdb_valid = 0;
    checks++; if (iv !== {1'b1, 1'b0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0}) begin errors++; $display("FAIL cdb_rename_bypass got %h want qj 0", iv); end
    push(mk(3, 1, 4, 0));
    idle();
    checks++; if (iv !== {1'b0, 1'b1, 3'd3, 3'd1, 3'd4, 3'd2, 3'd2}) begin errors++; $display("FAIL cdb_rename_wins got %h want qj 2 qk 2", iv); end
  endtask

  task automatic test_stall();
    LSFull = 1;
    push(mk(3, 2, 3, 0));
    push(mk(0, 6, 7, 0));
    checks++; if ({as_issue, ls_issue} !== 2'b00) begin errors++; $display("FAIL stall_c1 got %b want 00", {as_issue, ls_issue}); end
    idle();
    checks++; if ({as_issue, ls_issue} !== 2'b00) begin errors++; $display("FAIL stall_c2 got %b want 00", {as_issue, ls_issue}); end
    idle();
    checks++; if ({as_issue, ls_issue} !== 2'b00 || stall_cnt !== 8'd3) begin errors++; $display("FAIL stall_c3 got %b cnt %0d want 00 cnt 3", {as_issue, ls_issue}, stall_cnt); end
    LSFull = 0;
    idle();
    checks++; if ({as_issue, ls_issue, iss_op, iss_rd} !== {1'b0, 1'b1, 3'd3, 3'd2}) begin errors++; $display("FAIL stall_st got %b/%0d/%0d", {as_issue, ls_issue}, iss_op, iss_rd); end
    idle();
    checks++; if ({as_issue, ls_issue, iss_op, iss_rd} !== {1'b1, 1'b0, 3'd0, 3'd6}) begin errors++; $display("FAIL stall_add got %b/%0d/%0d", {as_issue, ls_issue}, iss_op, iss_rd); end
  endtask

  task automatic test_full_wrap();
    logic [15:0] w [10];
    for (int i = 0; i < 10; i++) w[i] = mk($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 127));
    ASFull = 1; LSFull = 1;
    for (int i = 0; i < 4; i++) push(w[i]);
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", instr_ready); end
    push(mk(0, 7, 7, 0));
    checks++; if (instr_ready !== 1'b0 || {as_issue, ls_issue} !== 2'b00) begin errors++; $display("FAIL full_5th got ready %b strobes %b want 0 00", instr_ready, {as_issue, ls_issue}); end
    ASFull = 0; LSFull = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      checks++; if ({as_issue, ls_issue, iss_op, iss_rd, iss_rs} !== {w[i][2:1] == 2'b00, w[i][2:1] == 2'b01, w[i][2:0], w[i][5:3], w[i][8:6]}) begin errors++; $display("FAIL full_drain %0d got %h want instr %h", i, iv, w[i]); end
    end
    idle();
    checks++; if ({as_issue, ls_issue} !== 2'b00) begin errors++; $display("FAIL full_dropped got %b want 00", {as_issue, ls_issue}); end
    for (int i = 4; i <= 10; i++) begin
      if (i < 10) push(w[i]); else idle();
      if (i > 4) begin
        checks++; if ({as_issue, ls_issue, iss_op, iss_rd, iss_rs} !== {w[i-1][2:1] == 2'b00, w[i-1][2:1] == 2'b01, w[i-1][2:0], w[i-1][5:3], w[i-1][8:6]}) begin errors++; $display("FAIL wrap %0d got %h want instr %h", i - 1, iv, w[i-1]); end
      end
    end
  endtask

  task automatic test_reserved();
    push(mk(6, 1, 1, 0));
    push(mk(0, 2, 3, 0));
    checks++; if ({as_issue, ls_issue} !== 2'b00) begin errors++; $display("FAIL rsv_nostrobe got %b want 00", {as_issue, ls_issue}); end
    idle();
    checks++; if ({as_issue, ls_issue, iss_op, iss_rd, iss_rs} !== {1'b1, 1'b0, 3'd0, 3'd2, 3'd3}) begin errors++; $display("FAIL rsv_next got %h want ADD r2,r3", iv); end
  endtask

  task automatic test_saturate();
    ASFull = 1;
    push(mk(0, 0, 0, 0));
    repeat (260) idle();
    checks++; if (stall_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d want 255", stall_cnt); end
    ASFull = 0;
    idle();
    checks++; if (stall_cnt !== 8'd255 || as_issue !== 1'b1) begin errors++; $display("FAIL sat_release got cnt %0d as %b want 255 1", stall_cnt, as_issue); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      instr_valid = ($urandom % 4) != 0;
      instr = mk(($urandom % 8 == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 127));
      ASFull = ($urandom % 3) == 0;
      LSFull = ($urandom % 3) == 0;
      as_tag = 3'($urandom_range(1, 3));
      ls_tag = 3'($urandom_range(4, 7));
      cdb_valid = $urandom % 2;
      cdb_tag = 3'($urandom_range(1, 7));
      tick();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL random cyc %0d got %h want %h", n, obs, exp_vec()); end
    end
    instr_valid = 0; cdb_valid = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rename();
    test_cdb();
    test_stall();
    test_full_wrap();
    test_reserved();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
